// File: rtl/alu_chk_pkg.sv
// rtl/alu_chk_pkg.sv - shared types and widths for the ALU stimulus/checker engine
package alu_chk_pkg;

    localparam int CMD_W  = 3;
    localparam int DIN_W  = 8;
    localparam int DOUT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DIN_W-1:0]  a;
        logic [DIN_W-1:0]  b;
        logic [DOUT_W-1:0] exp;
    } pattern_t;

    // An expected value of zero is a don't-care only when zero skipping is built in.
    function automatic logic result_mismatch(input logic [DOUT_W-1:0] obs,
                                             input logic [DOUT_W-1:0] exp,
                                             input logic              zero_skip);
        return (obs != exp) && !(zero_skip && (exp == '0));
    endfunction

endpackage

// File: rtl/alu_chk_delay.sv
// rtl/alu_chk_delay.sv - LAT-stage shift register carrying {valid, exp, idx} alongside the ALU pipeline
module alu_chk_delay
    import alu_chk_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int IDX_W = 7
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              push_valid_i,
    input  logic [DOUT_W-1:0] push_exp_i,
    input  logic [IDX_W-1:0]  push_idx_i,
    output logic              head_valid_o,
    output logic [DOUT_W-1:0] head_exp_o,
    output logic [IDX_W-1:0]  head_idx_o
);

    localparam int W = 1 + DOUT_W + IDX_W;

    logic [W-1:0] stage_q [LAT];
    logic [W-1:0] stage_d [LAT];

    always_comb begin
        stage_d[0] = {push_valid_i, push_exp_i, push_idx_i};
        for (int i = 1; i < LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign {head_valid_o, head_exp_o, head_idx_o} = stage_q[LAT-1];

endmodule

// File: rtl/alu_stim_checker.sv
// rtl/alu_stim_checker.sv - pattern buffer, issue FSM and result checker for the ALU BIST wrapper
// Optional build macro ZERO_SKIP_EN: expected value 16'h0000 is treated as don't-care.
module alu_stim_checker
    import alu_chk_pkg::*;
#(
    parameter int DEPTH = 80,
    parameter int LAT   = 2,
    parameter int ERR_W = 8
) (
    input  logic                     clk_p_i,
    input  logic                     reset_n_i,
    input  logic                     ld_valid_i,
    output logic                     ld_ready_o,
    input  logic [CMD_W-1:0]         ld_cmd_i,
    input  logic [DIN_W-1:0]         ld_a_i,
    input  logic [DIN_W-1:0]         ld_b_i,
    input  logic [DOUT_W-1:0]        ld_exp_i,
    input  logic                     start_i,
    input  logic                     clear_i,
    output logic [CMD_W-1:0]         inst_o,
    output logic [DIN_W-1:0]         data_a_o,
    output logic [DIN_W-1:0]         data_b_o,
    input  logic [DOUT_W-1:0]        data_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     pass_o,
    output logic [ERR_W-1:0]         err_cnt_o,
    output logic [$clog2(DEPTH)-1:0] first_err_o
);

    localparam int RP_W = $clog2(DEPTH);
    localparam int WP_W = $clog2(DEPTH + 1);
    localparam int DC_W = $clog2(LAT + 1);
    localparam logic [WP_W-1:0] DEPTH_V = WP_W'(DEPTH);
    localparam logic [DC_W-1:0] LAT_M1  = DC_W'(LAT - 1);
`ifdef ZERO_SKIP_EN
    localparam logic ZERO_SKIP = 1'b1;
`else
    localparam logic ZERO_SKIP = 1'b0;
`endif

    pattern_t          mem_q [DEPTH];
    state_e            state_q, state_d;
    logic [WP_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [RP_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DC_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [CMD_W-1:0]  inst_q, inst_d;
    logic [DIN_W-1:0]  data_a_q, data_a_d;
    logic [DIN_W-1:0]  data_b_q, data_b_d;
    logic              done_q, done_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [RP_W-1:0]   first_err_q, first_err_d;

    logic              ld_fire;
    logic              issue;
    logic              check_en;
    logic              mismatch;
    pattern_t          cur;
    pattern_t          ld_pat;
    logic              dl_valid;
    logic [DOUT_W-1:0] dl_exp;
    logic [RP_W-1:0]   dl_idx;

    assign ld_ready_o = (state_q == IDLE) && (wr_ptr_q < DEPTH_V);
    assign ld_fire    = ld_valid_i && ld_ready_o && !clear_i;
    assign ld_pat     = '{cmd: ld_cmd_i, a: ld_a_i, b: ld_b_i, exp: ld_exp_i};
    assign cur        = mem_q[rd_ptr_q];
    assign issue      = (state_q == RUN) && !clear_i;

    // Pattern storage is deliberately not reset; wr_ptr alone defines what is valid.
    always_ff @(posedge clk_p_i) begin
        if (ld_fire) begin
            mem_q[RP_W'(wr_ptr_q)] <= ld_pat;
        end
    end

    alu_chk_delay #(
        .LAT   (LAT),
        .IDX_W (RP_W)
    ) u_delay (
        .clk_i        (clk_p_i),
        .rst_n_i      (reset_n_i),
        .push_valid_i (issue),
        .push_exp_i   (cur.exp),
        .push_idx_i   (rd_ptr_q),
        .head_valid_o (dl_valid),
        .head_exp_o   (dl_exp),
        .head_idx_o   (dl_idx)
    );

    // Stale entries left in the delay line by a clear must not be scored.
    assign check_en = dl_valid && !clear_i && ((state_q == RUN) || (state_q == DRAIN));
    assign mismatch = check_en && result_mismatch(data_i, dl_exp, ZERO_SKIP);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = done_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        inst_d      = '0;
        data_a_d    = '0;
        data_b_d    = '0;

        if (issue) begin
            inst_d   = cur.cmd;
            data_a_d = cur.a;
            data_b_d = cur.b;
        end

        case (state_q)
            IDLE: begin
                if (ld_fire) begin
                    wr_ptr_d = wr_ptr_q + WP_W'(1);
                end
                if (start_i && ((wr_ptr_q != '0) || ld_fire)) begin
                    state_d  = RUN;
                    rd_ptr_d = '0;
                end
            end
            RUN: begin
                rd_ptr_d = rd_ptr_q + RP_W'(1);
                if (WP_W'(rd_ptr_q) == (wr_ptr_q - WP_W'(1))) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == LAT_M1) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DC_W'(1);
                end
            end
            DONE: begin
                if (start_i) begin
                    state_d     = RUN;
                    rd_ptr_d    = '0;
                    done_d      = 1'b0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (mismatch) begin
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            if (err_cnt_q == '0) begin
                first_err_d = dl_idx;
            end
        end

        if (clear_i) begin
            state_d     = IDLE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            drain_cnt_d = '0;
            done_d      = 1'b0;
            err_cnt_d   = '0;
            first_err_d = '0;
        end
    end

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            drain_cnt_q <= '0;
            inst_q      <= '0;
            data_a_q    <= '0;
            data_b_q    <= '0;
            done_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            drain_cnt_q <= drain_cnt_d;
            inst_q      <= inst_d;
            data_a_q    <= data_a_d;
            data_b_q    <= data_b_d;
            done_q      <= done_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
        end
    end

    assign inst_o      = inst_q;
    assign data_a_o    = data_a_q;
    assign data_b_o    = data_b_q;
    assign busy_o      = (state_q == RUN) || (state_q == DRAIN);
    assign done_o      = done_q;
    assign pass_o      = done_q && (err_cnt_q == '0);
    assign err_cnt_o   = err_cnt_q;
    assign first_err_o = first_err_q;

endmodule

// File: tb/tb_alu_stim_checker.sv
// tb/tb_alu_stim_checker.sv - directed plus randomized self-checking bench for alu_stim_checker
module tb_alu_stim_checker;

    localparam int DEPTH = 80;
    localparam int LAT   = 2;
`ifdef ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  cmd;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } pat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid, start, clear;
    logic [2:0]  ld_cmd;
    logic [7:0]  ld_a, ld_b;
    logic [15:0] ld_exp;
    logic        ld_ready, ld_ready4;
    logic [2:0]  inst_o, inst4;
    logic [7:0]  data_a_o, data_b_o, data_a4, data_b4;
    logic [15:0] alu_q, data_i, data_i4;
    logic        busy_o, done_o, pass_o, busy4, done4, pass4;
    logic [7:0]  err_cnt;
    logic [3:0]  err_cnt4;
    logic [6:0]  first_err, first_err4;

    int   n_chk  = 0;
    int   n_fail = 0;
    pat_t pats[$];
    bit   bad_a[256];

    always #5 clk = ~clk;

    alu_stim_checker #(.DEPTH(DEPTH), .LAT(LAT), .ERR_W(8)) dut (
        .clk_p_i(clk), .reset_n_i(rst_n), .ld_valid_i(ld_valid), .ld_ready_o(ld_ready),
        .ld_cmd_i(ld_cmd), .ld_a_i(ld_a), .ld_b_i(ld_b), .ld_exp_i(ld_exp),
        .start_i(start), .clear_i(clear), .inst_o(inst_o), .data_a_o(data_a_o),
        .data_b_o(data_b_o), .data_i(data_i), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .err_cnt_o(err_cnt), .first_err_o(first_err)
    );

    alu_stim_checker #(.DEPTH(DEPTH), .LAT(LAT), .ERR_W(4)) dut4 (
        .clk_p_i(clk), .reset_n_i(rst_n), .ld_valid_i(ld_valid), .ld_ready_o(ld_ready4),
        .ld_cmd_i(ld_cmd), .ld_a_i(ld_a), .ld_b_i(ld_b), .ld_exp_i(ld_exp),
        .start_i(start), .clear_i(clear), .inst_o(inst4), .data_a_o(data_a4),
        .data_b_o(data_b4), .data_i(data_i4), .busy_o(busy4), .done_o(done4),
        .pass_o(pass4), .err_cnt_o(err_cnt4), .first_err_o(first_err4)
    );

    function automatic logic [15:0] alu_ref(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
        case (c)
            3'd0:    return {8'h00, a} + {8'h00, b};
            3'd1:    return {8'h00, a} - {8'h00, b};
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a | b};
            3'd4:    return {8'h00, a ^ b};
            3'd5:    return 16'(a) * 16'(b);
            3'd6:    return {7'h00, a, 1'b0};
            default: return {8'h00, ~a};
        endcase
    endfunction

    function automatic logic [15:0] alu_out(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
        return alu_ref(c, a, b) ^ (bad_a[a] ? 16'h5A5A : 16'h0000);
    endfunction

    // Two-stage ALU: result of stimulus registered at edge N is sampled by the checker at N+2.
    always @(posedge clk) alu_q <= alu_out(inst_o, data_a_o, data_b_o);
    assign data_i  = alu_q;
    assign data_i4 = ~alu_q;

    function automatic void expect_run(input int errw, input bit inverted, output int err, output int first);
        int          cnt;
        logic [15:0] obs;
        cnt   = 0;
        first = 0;
        for (int i = 0; i < pats.size(); i++) begin
            obs = alu_out(pats[i].cmd, pats[i].a, pats[i].b);
            if (inverted) obs = ~obs;
            if ((obs != pats[i].exp) && !(SKIP && (pats[i].exp == 16'h0000))) begin
                if (cnt == 0) first = i;
                cnt++;
            end
        end
        err = (cnt > (1 << errw) - 1) ? (1 << errw) - 1 : cnt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] e, input bit with_start);
        chk("ld_ready", ld_ready, pats.size() < DEPTH);
        ld_valid = 1'b1; ld_cmd = c; ld_a = a; ld_b = b; ld_exp = e; start = with_start;
        step();
        ld_valid = 1'b0; start = 1'b0;
        if (pats.size() < DEPTH) pats.push_back('{cmd: c, a: a, b: b, exp: e});
    endtask

    task automatic load_random(input int n);
        logic [2:0] c;
        logic [7:0] a, b;
        logic [15:0] e;
        for (int i = 0; i < n; i++) begin
            c = 3'($urandom_range(0, 7));
            a = 8'($urandom);
            b = 8'($urandom);
            e = ($urandom_range(0, 7) == 0) ? 16'($urandom) : alu_ref(c, a, b);
            load(c, a, b, e, 1'b0);
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        pats.delete();
    endtask

    task automatic run_check(input string tag, input bit start_now, input bit poke);
        int cyc, e_err, e_first, e4_err, e4_first;
        if (start_now) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        chk({tag, "_busy"}, busy_o, 1'b1);
        cyc = 0;
        while (!done_o && cyc < 4 * DEPTH) begin
            if (poke && cyc == 3) start = 1'b1;
            step();
            start = 1'b0;
            cyc++;
            if (cyc == 1) chk({tag, "_ready_busy"}, ld_ready, 1'b0);
        end
        chk({tag, "_latency"}, cyc, pats.size() + LAT);
        expect_run(8, 1'b0, e_err, e_first);
        expect_run(4, 1'b1, e4_err, e4_first);
        chk({tag, "_done"}, done_o, 1'b1);
        chk({tag, "_busy_end"}, busy_o, 1'b0);
        chk({tag, "_err"}, err_cnt, e_err);
        chk({tag, "_first"}, first_err, e_first);
        chk({tag, "_pass"}, pass_o, e_err == 0);
        chk({tag, "_err4"}, err_cnt4, e4_err);
        chk({tag, "_first4"}, first_err4, e4_first);
    endtask

    initial begin
        rst_n = 1'b0; ld_valid = 1'b0; start = 1'b0; clear = 1'b0;
        ld_cmd = '0; ld_a = '0; ld_b = '0; ld_exp = '0;
        for (int i = 0; i < 256; i++) bad_a[i] = 1'b0;
        step();
        step();
        chk("rst_ready", ld_ready, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_pass", pass_o, 1'b0);
        chk("rst_err", err_cnt, 8'h00);
        chk("rst_first", first_err, 7'h00);
        chk("rst_outs", {inst_o, data_a_o, data_b_o}, 19'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Four directed patterns, start coincident with the last write.
        load(3'd0, 8'h03, 8'h04, 16'h0007, 1'b0);
        load(3'd1, 8'h09, 8'h02, 16'h0007, 1'b0);
        load(3'd2, 8'hF0, 8'h3C, 16'h0030, 1'b0);
        load(3'd5, 8'h10, 8'h10, 16'h0100, 1'b1);
        run_check("t1", 1'b0, 1'b0);
        chk("t1_pass_const", pass_o, 1'b1);

        // Replay with the ALU corrupting entry 2.
        bad_a[8'hF0] = 1'b1;
        run_check("t2", 1'b1, 1'b0);
        chk("t2_first_const", first_err, 7'd2);
        bad_a[8'hF0] = 1'b0;

        // Clear, then start on an empty buffer must be ignored.
        pulse_clear();
        chk("clr_done", done_o, 1'b0);
        chk("clr_ready", ld_ready, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("empty_start", busy_o, 1'b0);

        // Zero expected value against a nonzero ALU result (0xE9 * 0x14 = 0x1234).
        load(3'd5, 8'hE9, 8'h14, 16'h0000, 1'b0);
        load(3'd0, 8'h01, 8'h01, 16'h0002, 1'b0);
        run_check("t4", 1'b1, 1'b0);
        chk("t4_zero", err_cnt, SKIP ? 8'd0 : 8'd1);

        // Overfill, random run with an ignored mid-run start; dut4 sees all mismatches and saturates.
        pulse_clear();
        for (int i = 0; i < 256; i++) bad_a[i] = ($urandom_range(0, 15) == 0);
        load_random(DEPTH + 3);
        chk("full_ready", ld_ready, 1'b0);
        run_check("t3", 1'b1, 1'b1);
        chk("t5_sat", err_cnt4, 4'hF);
        for (int i = 0; i < 256; i++) bad_a[i] = ($urandom_range(0, 3) == 0);
        run_check("t3b", 1'b1, 1'b0);

        // Asynchronous reset in the middle of a run.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_ready", ld_ready, 1'b1);
        chk("arst_err", err_cnt, 8'h00);
        chk("arst_outs", {inst_o, data_a_o, data_b_o}, 19'h0);
        @(negedge clk);
        rst_n = 1'b1;
        pats.delete();
        step();
        for (int i = 0; i < 256; i++) bad_a[i] = ($urandom_range(0, 7) == 0);
        load_random(5);
        run_check("t6", 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
